onchip_memory_seq_master: RTL and testbench
===========================================

Name: onchip_memory_seq_master

Overview:
- Avalon-MM master that drives the 16-bit single-port on-chip memory slave (15-bit word address, 2-bit byteenable, fixed 1-cycle read latency, no waitrequest).
- On command it fills a word range with an incrementing pattern, or reads the range back and checks it against the same pattern.
- Used for memory init, self-test and testbench stimulus; it is the only master on the slave port while busy.

Parameters:
- ADDR_W, 15, word address width (32768 words).
- DATA_W, 16, data width; multiple of 8.
- BE_W, DATA_W/8, byteenable width.
- LEN_W, 16, transfer-length width; must hold 2^ADDR_W.
- ERR_W, 16, error-counter width; counter saturates.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = FILL, 1 = VERIFY.
- base_addr  in  ADDR_W  first word address.
- length  in  LEN_W  number of words (0 allowed).
- seed  in  DATA_W  pattern value for the first word.
- byte_mask  in  BE_W  byteenable used for FILL writes.
- abort  in  1  stop issuing accesses; takes effect on the next edge.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  set with done if abort ended the run; cleared on the next start.
- err_count  out  ERR_W  VERIFY mismatch count, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- mem_address  out  ADDR_W  Avalon address.
- mem_byteenable  out  BE_W  Avalon byteenable.
- mem_chipselect  out  1  Avalon chipselect.
- mem_write  out  1  Avalon write.
- mem_writedata  out  DATA_W  Avalon writedata.
- mem_clken  out  1  slave clock enable; constant 1.
- mem_readdata  in  DATA_W  Avalon readdata; valid 1 cycle after a read is issued.

Behaviour:
- Reset values: all outputs 0 except mem_clken = 1. The FSM goes to IDLE.
- Reset mid-run: the access stops on the same edge, no done pulse is generated, and err_count and first_err_addr clear.
- FSM states are IDLE, FILL, READ, DRAIN, FINISH.
- IDLE: start = 1 latches all command inputs and clears err_count, first_err_addr and aborted.
  - length = 0 goes to FINISH with no access.
  - op = 0 goes to FILL; op = 1 goes to READ.
  - start while busy is ignored.
- Timing is measured from the start-accept edge N. Word i (0 ≤ i < L) is issued in cycle N+1+i with one access per cycle and no gaps.
- Addressing: mem_address = (base_addr + i) mod 2^ADDR_W, so the range wraps at 2^ADDR_W.
- Pattern: word i expects (seed + i) mod 2^DATA_W.
- FILL:
  - mem_chipselect = 1 and mem_write = 1, with mem_byteenable = byte_mask and mem_writedata = pattern.
  - After the last write the next state is FINISH, so done is high in cycle N+L+1.
- READ:
  - mem_chipselect = 1, mem_write = 0, mem_byteenable = all ones.
  - A 1-deep shift register holds the expected value and address of each issued read.
  - In cycle N+2+i, mem_readdata is compared against pattern i on the full width (byte_mask is ignored).
  - A mismatch increments err_count, which saturates at 2^ERR_W−1.
  - On the first mismatch only, first_err_addr is loaded with that word's address.
  - After the last read the next state is DRAIN, where the final compare happens. Then FINISH, so done is high in cycle N+L+2.
- FINISH: pulses done for one cycle and returns to IDLE. busy falls on the same edge that done falls.
- Outside FILL and READ, mem_chipselect, mem_write and mem_byteenable are all 0.
- abort:
  - In FILL: no further writes; go to FINISH with aborted = 1.
  - In READ: no further reads; go to DRAIN so the outstanding read is still compared, then FINISH with aborted = 1.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- The final err_count and first_err_addr hold until the next accepted start.

Test Plan:
- FILL base=0x0010, L=4, seed=0xA000, mask=11 → writes 0xA000..0xA003 to 0x0010..0x0013 in cycles N+1..N+4; done in cycle N+5; memory model matches.
- VERIFY the same range against an unmodified model → reads in N+1..N+4; done in N+6; err_count=0.
- Corrupt 0x0012 to 0x0000, then VERIFY → err_count=1, first_err_addr=0x0012.
- Wrap case: FILL base=0x7FFE, L=4, seed=0xFFFF → writes 0xFFFF,0x0000,0x0001,0x0002 to addresses 0x7FFE,0x7FFF,0x0000,0x0001.
- Zero length and busy start: L=0 → done in N+1, chipselect never high. A start pulse during a FILL of L=8 is ignored and the run completes unchanged.
- Abort in VERIFY L=16 at issue i=5 → exactly 6 reads issued and 6 compares performed, then done with aborted=1. A reset asserted in a later run drives chipselect low on the next edge and produces no done.

Source files
------------

// File: rtl/onchip_memory_seq_master.sv
// Avalon-MM sequencer for the 16-bit on-chip memory: fills a word range with an
// incrementing pattern or reads it back and counts mismatches against that pattern.
module onchip_memory_seq_master #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = DATA_W / 8,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] seed,
    input  logic [BE_W-1:0]   byte_mask,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic                abort_hit_q, abort_hit_d;
    logic [BE_W-1:0]     mask_q, mask_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [BE_W-1:0]     mem_byteenable_q, mem_byteenable_d;
    logic                mem_chipselect_q, mem_chipselect_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;

    // Next-state logic; bus outputs are derived from the next state so they are
    // registered yet line up with the cycle the access belongs to.
    always_comb begin
        state_d          = state_q;
        remain_d         = remain_q;
        abort_hit_d      = abort_hit_q;
        mask_d           = mask_q;
        aborted_d        = aborted_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        cmp_valid_d      = (state_q == ST_READ);
        cmp_exp_d        = mem_writedata_q;
        cmp_addr_d       = mem_address_q;

        // Read issued last cycle returns data now
        if (cmp_valid_q && (mem_readdata != cmp_exp_q)) begin
            if (err_count_q == '0) begin
                first_err_addr_d = cmp_addr_q;
            end
            if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aborted_d        = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    abort_hit_d      = 1'b0;
                    mask_d           = byte_mask;
                    mem_address_d    = base_addr;
                    mem_writedata_d  = seed;
                    remain_d         = length;
                    if (length == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = op ? ST_READ : ST_FILL;
                    end
                end
            end
            ST_FILL, ST_READ: begin
                if (abort || (remain_q == LEN_W'(1))) begin
                    state_d     = (state_q == ST_FILL) ? ST_FINISH : ST_DRAIN;
                    abort_hit_d = abort_hit_q | abort;
                end else begin
                    mem_address_d   = mem_address_q + ADDR_W'(1);
                    mem_writedata_d = mem_writedata_q + DATA_W'(1);
                    remain_d        = remain_q - LEN_W'(1);
                end
            end
            ST_DRAIN:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
            aborted_d = abort_hit_d;
        end

        busy_d           = (state_d != ST_IDLE);
        done_d           = (state_d == ST_FINISH);
        mem_chipselect_d = (state_d == ST_FILL) || (state_d == ST_READ);
        mem_write_d      = (state_d == ST_FILL);
        if (state_d == ST_FILL) begin
            mem_byteenable_d = mask_d;
        end else if (state_d == ST_READ) begin
            mem_byteenable_d = {BE_W{1'b1}};
        end else begin
            mem_byteenable_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            remain_q         <= '0;
            abort_hit_q      <= 1'b0;
            mask_q           <= '0;
            cmp_valid_q      <= 1'b0;
            cmp_exp_q        <= '0;
            cmp_addr_q       <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            aborted_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            remain_q         <= remain_d;
            abort_hit_q      <= abort_hit_d;
            mask_q           <= mask_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_exp_q        <= cmp_exp_d;
            cmp_addr_q       <= cmp_addr_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            aborted_q        <= aborted_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_memory_seq_master.sv
// Bench for onchip_memory_seq_master: memory slave model plus a per-cycle
// expectation queue built from command-level rules.
module tb_onchip_memory_seq_master;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned LW = 16;
    localparam int unsigned EW = 16;

    logic          clk = 1'b0;
    logic          reset, start, op, abort;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic [DW-1:0] seed;
    logic [BW-1:0] byte_mask;
    logic          busy, done, aborted;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;

    bit   [DW-1:0] slave_mem [0:32767];
    bit   [DW-1:0] ref_mem   [0:32767];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          aborted;
        logic          cs;
        logic          wr;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [EW-1:0] err;
        logic [AW-1:0] ferr;
    } exp_t;

    exp_t          exp_q[$];
    logic [EW-1:0] hold_err  = '0;
    logic [AW-1:0] hold_ferr = '0;
    logic          hold_ab   = 1'b0;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cs_seen = 0;
    int            done_seen = 0;

    always #5 clk = ~clk;

    onchip_memory_seq_master dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .byte_mask      (byte_mask),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // On-chip memory slave: byte-masked writes, 1-cycle read latency
    always @(posedge clk) begin
        if (poke_en) begin
            slave_mem[poke_addr] <= poke_data;
        end else if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) slave_mem[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) slave_mem[mem_address][15:8] <= mem_writedata[15:8];
        end
        if (mem_chipselect && !mem_write) begin
            mem_readdata <= slave_mem[mem_address];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Per-cycle output check against the expectation queue (idle when empty)
    always begin : cmp_proc
        exp_t e;
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            e         = '0;
            e.err     = hold_err;
            e.ferr    = hold_ferr;
            e.aborted = hold_ab;
        end
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("aborted", 32'(aborted), 32'(e.aborted));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("first_err_addr", 32'(first_err_addr), 32'(e.ferr));
        chk("chipselect", 32'(mem_chipselect), 32'(e.cs));
        chk("write", 32'(mem_write), 32'(e.wr));
        chk("byteenable", 32'(mem_byteenable), 32'(e.be));
        chk("clken", 32'(mem_clken), 32'd1);
        if (e.cs) chk("address", 32'(mem_address), 32'(e.addr));
        if (e.wr) chk("writedata", 32'(mem_writedata), 32'(e.wdata));
        cs_seen   += int'(mem_chipselect);
        done_seen += int'(done);
    end

    // Expand one accepted command into per-cycle expectations for cycles N+1..N+total
    task automatic push_cmd(input logic o, input logic [AW-1:0] b, input int len,
                            input logic [DW-1:0] s, input logic [BW-1:0] m,
                            input int ab_at, output int total);
        int            leff;
        bit            abd;
        bit            mis[$];
        logic [AW-1:0] a;
        logic [DW-1:0] p;
        int            k;
        int            nerr;
        logic [AW-1:0] fe;
        exp_t          e;
        abd  = (ab_at >= 0) && (ab_at < len);
        leff = abd ? ab_at + 1 : len;
        if (len == 0) total = 1;
        else          total = o ? leff + 2 : leff + 1;
        for (int i = 0; i < leff; i++) begin
            a = b + AW'(i);
            p = s + DW'(i);
            if (o) begin
                mis.push_back(ref_mem[a] != p);
            end else begin
                if (m[0]) ref_mem[a][7:0]  = p[7:0];
                if (m[1]) ref_mem[a][15:8] = p[15:8];
                mis.push_back(1'b0);
            end
        end
        e = '0;
        for (int c = 1; c <= total; c++) begin
            e         = '0;
            e.busy    = 1'b1;
            e.done    = (c == total);
            e.aborted = e.done && abd;
            e.cs      = (c <= leff);
            e.wr      = e.cs && !o;
            e.be      = e.cs ? (o ? 2'b11 : m) : 2'b00;
            e.addr    = b + AW'(c - 1);
            e.wdata   = s + DW'(c - 1);
            k = c - 2;
            if (k < 0) k = 0;
            if (k > leff) k = leff;
            nerr = 0;
            fe   = '0;
            for (int j = 0; j < k; j++) begin
                if (mis[j]) begin
                    if (nerr == 0) fe = b + AW'(j);
                    if (nerr < 65535) nerr++;
                end
            end
            e.err  = EW'(nerr);
            e.ferr = fe;
            exp_q.push_back(e);
        end
        hold_err  = e.err;
        hold_ferr = e.ferr;
        hold_ab   = abd;
    endtask

    task automatic run(input logic o, input logic [AW-1:0] b, input int len,
                       input logic [DW-1:0] s, input logic [BW-1:0] m,
                       input int ab_at, input int busy_at, input bit ab_with_start);
        int total;
        @(negedge clk);
        op = o; base_addr = b; length = LW'(len); seed = s; byte_mask = m;
        start = 1'b1;
        abort = ab_with_start;
        push_cmd(o, b, len, s, m, ab_at, total);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= total; c++) begin
            abort = (ab_at >= 0) && (c == ab_at + 1);
            if (c == busy_at) begin
                start = 1'b1; op = ~o; base_addr = ~b; length = LW'(3); seed = ~s;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic mem_check(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = b + AW'(i);
            chk("mem_content", 32'(slave_mem[a]), 32'(ref_mem[a]));
        end
    endtask

    initial begin
        int c0, d0;
        logic          ro;
        logic [AW-1:0] rb;
        int            rlen, rab;
        logic [DW-1:0] rs;
        logic [BW-1:0] rm;
        reset = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; seed = '0; byte_mask = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fill
        c0 = cs_seen; d0 = done_seen;
        run(1'b0, 15'h0010, 4, 16'hA000, 2'b11, -1, -1, 1'b0);
        chk("fill_w0_lit", 32'(slave_mem[15'h0010]), 32'h0000_A000);
        chk("fill_w3_lit", 32'(slave_mem[15'h0013]), 32'h0000_A003);
        chk("fill_cs_cycles", 32'(cs_seen - c0), 32'd4);
        chk("fill_done_pulses", 32'(done_seen - d0), 32'd1);
        mem_check(15'h0010, 4);

        // Clean verify, then verify with one corrupted word
        run(1'b1, 15'h0010, 4, 16'hA000, 2'b00, -1, -1, 1'b0);
        chk("verify_clean_err_lit", 32'(err_count), 32'd0);
        poke(15'h0012, 16'h0000);
        run(1'b1, 15'h0010, 4, 16'hA000, 2'b00, -1, -1, 1'b0);
        chk("verify_corrupt_err_lit", 32'(err_count), 32'd1);
        chk("verify_corrupt_addr_lit", 32'(first_err_addr), 32'h0012);

        // Address and pattern wrap
        run(1'b0, 15'h7FFE, 4, 16'hFFFF, 2'b11, -1, -1, 1'b0);
        chk("wrap_7ffe_lit", 32'(slave_mem[15'h7FFE]), 32'h0000_FFFF);
        chk("wrap_7fff_lit", 32'(slave_mem[15'h7FFF]), 32'h0000_0000);
        chk("wrap_0000_lit", 32'(slave_mem[15'h0000]), 32'h0000_0001);
        chk("wrap_0001_lit", 32'(slave_mem[15'h0001]), 32'h0000_0002);

        // Zero length, then start while busy
        c0 = cs_seen; d0 = done_seen;
        run(1'b0, 15'h0040, 0, 16'h1234, 2'b11, -1, -1, 1'b0);
        chk("zero_len_cs_lit", 32'(cs_seen - c0), 32'd0);
        chk("zero_len_done_lit", 32'(done_seen - d0), 32'd1);
        c0 = cs_seen;
        run(1'b0, 15'h0100, 8, 16'h5555, 2'b01, -1, 3, 1'b0);
        chk("busy_start_cs_lit", 32'(cs_seen - c0), 32'd8);
        mem_check(15'h0100, 8);

        // Abort during verify of a range that mismatches everywhere
        run(1'b0, 15'h0200, 16, 16'h1000, 2'b11, -1, -1, 1'b0);
        c0 = cs_seen;
        run(1'b1, 15'h0200, 16, 16'h2000, 2'b00, 5, -1, 1'b0);
        chk("abort_rd_cs_lit", 32'(cs_seen - c0), 32'd6);
        chk("abort_rd_err_lit", 32'(err_count), 32'd6);
        chk("abort_rd_ferr_lit", 32'(first_err_addr), 32'h0200);
        chk("abort_rd_flag_lit", 32'(aborted), 32'd1);

        // Abort during fill
        c0 = cs_seen;
        run(1'b0, 15'h0400, 10, 16'h0BEE, 2'b11, 2, -1, 1'b0);
        chk("abort_wr_cs_lit", 32'(cs_seen - c0), 32'd3);
        mem_check(15'h0400, 10);

        // Abort in idle is ignored; abort together with start loses to start
        d0 = done_seen;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_abort_done_lit", 32'(done_seen - d0), 32'd0);
        run(1'b1, 15'h0200, 4, 16'h1000, 2'b00, -1, -1, 1'b1);
        chk("abort_start_flag_lit", 32'(aborted), 32'd0);

        // Reset in the middle of a verify run
        @(negedge clk);
        op = 1'b1; base_addr = 15'h0200; length = LW'(10); seed = 16'h7777; byte_mask = 2'b00;
        start = 1'b1;
        begin
            int t;
            push_cmd(1'b1, 15'h0200, 10, 16'h7777, 2'b00, -1, t);
        end
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_seen;
        reset = 1'b1;
        exp_q.delete();
        hold_err = '0; hold_ferr = '0; hold_ab = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("reset_no_done_lit", 32'(done_seen - d0), 32'd0);
        chk("reset_err_clear_lit", 32'(err_count), 32'd0);

        // Randomized commands
        for (int r = 0; r < 40; r++) begin
            ro   = 1'($urandom);
            rb   = AW'($urandom);
            rlen = int'($urandom % 32'd25);
            rs   = DW'($urandom);
            rm   = BW'($urandom);
            rab  = -1;
            if ((rlen > 1) && ($urandom % 32'd4 == 32'd0)) rab = int'($urandom % 32'(rlen - 1));
            if (ro && (rlen > 0) && ($urandom % 32'd2 == 32'd0))
                poke(rb + AW'($urandom % 32'(rlen)), DW'($urandom));
            run(ro, rb, rlen, rs, rm, rab, -1, 1'b0);
            if (!ro) mem_check(rb, rlen);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
